// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Stall/forward controller for the pipelined MIPS core. Tracks
//               destination, write-enable and Tnew of every in-flight stage
//               after D and compares them with the D-stage Tuse values to
//               produce the stall and the D-stage forward selects.
//               Optional multiply/divide busy counter, enabled by defining
//               the macro HAZARD_MD_EN.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
   parameter int NSTAGE  = 3,
   parameter int TW      = 3,
   parameter int AW      = 5,
   parameter int MUL_CYC = 5,
   parameter int DIV_CYC = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [AW-1:0]                 d_rs,
   input  logic [AW-1:0]                 d_rt,
   input  logic [TW-1:0]                 d_tuse_rs,
   input  logic [TW-1:0]                 d_tuse_rt,
   input  logic [AW-1:0]                 d_a3,
   input  logic                          d_regwrite,
   input  logic [TW-1:0]                 d_tnew,
   input  logic                          d_md_start,
   input  logic                          d_md_div,
   input  logic                          d_md_use,
   output logic                          stall,
   output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs_d,
   output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt_d,
   output logic                          md_busy
);

   localparam int FW = $clog2(NSTAGE+1);

   // Scoreboard entries; index 0 is the E stage, higher indices are older.
   logic [AW-1:0] r_a3   [NSTAGE];
   logic          r_we   [NSTAGE];
   logic [TW-1:0] r_tnew [NSTAGE];

   logic          w_rs_hit, w_rt_hit;
   logic [TW-1:0] w_rs_tnew, w_rt_tnew;
   logic [FW-1:0] w_rs_sel, w_rt_sel;
   logic          w_reg_stall;
   logic          w_md_stall;
   logic          w_stall;

   // Youngest-match search: iterate old to young so the lowest index wins.
   always_comb begin
      w_rs_hit  = 1'b0;
      w_rt_hit  = 1'b0;
      w_rs_tnew = '0;
      w_rt_tnew = '0;
      w_rs_sel  = '0;
      w_rt_sel  = '0;
      for (int k = NSTAGE-1; k >= 0; k--) begin
         if (d_rs != '0 && r_we[k] && r_a3[k] == d_rs) begin
            w_rs_hit  = 1'b1;
            w_rs_tnew = r_tnew[k];
            w_rs_sel  = FW'(k+1);
         end
         if (d_rt != '0 && r_we[k] && r_a3[k] == d_rt) begin
            w_rt_hit  = 1'b1;
            w_rt_tnew = r_tnew[k];
            w_rt_sel  = FW'(k+1);
         end
      end
   end

   // Stall when the needed value arrives later than D must consume it;
   // forward only when the youngest producer already holds the result.
   always_comb begin
      w_reg_stall = (w_rs_hit && (d_tuse_rs < w_rs_tnew)) ||
                    (w_rt_hit && (d_tuse_rt < w_rt_tnew));
      w_stall     = w_reg_stall || w_md_stall;
      stall       = w_stall;
      fwd_rs_d    = (w_rs_hit && w_rs_tnew == '0) ? w_rs_sel : '0;
      fwd_rt_d    = (w_rt_hit && w_rt_tnew == '0) ? w_rt_sel : '0;
   end

   // Pipeline the scoreboard: D enters entry 0 (bubble on stall), older
   // entries shift down with Tnew saturating at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NSTAGE; k++) begin
            r_a3[k]   <= '0;
            r_we[k]   <= 1'b0;
            r_tnew[k] <= '0;
         end
      end else begin
         if (w_stall) begin
            r_a3[0]   <= '0;
            r_we[0]   <= 1'b0;
            r_tnew[0] <= '0;
         end else begin
            r_a3[0]   <= d_a3;
            r_we[0]   <= d_regwrite && (d_a3 != '0);
            r_tnew[0] <= d_tnew;
         end
         for (int k = 1; k < NSTAGE; k++) begin
            r_a3[k]   <= r_a3[k-1];
            r_we[k]   <= r_we[k-1];
            r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
         end
      end
   end

`ifdef HAZARD_MD_EN
   localparam int MD_MAX = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
   localparam int CW     = $clog2(MD_MAX+1);

   logic [CW-1:0] r_md_cnt;

   // Multiply/divide busy counter: load on an accepted start, else count down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_md_cnt <= '0;
      end else if (d_md_start && !w_stall) begin
         r_md_cnt <= d_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
      end else if (r_md_cnt != '0) begin
         r_md_cnt <= r_md_cnt - CW'(1);
      end
   end

   assign w_md_stall = d_md_use && (r_md_cnt != '0);
   assign md_busy    = (r_md_cnt != '0);
`else
   // Without the md unit the md inputs carry no meaning.
   logic w_unused_md;
   assign w_unused_md = d_md_start ^ d_md_div ^ d_md_use;
   assign w_md_stall  = 1'b0;
   assign md_busy     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard (NSTAGE=3).
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

   localparam int NSTAGE = 3;
   localparam int TW     = 3;
   localparam int AW     = 5;
   localparam int FW     = $clog2(NSTAGE+1);

`ifdef HAZARD_MD_EN
   localparam int MD_ON = 1;
`else
   localparam int MD_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] d_rs, d_rt, d_a3;
   logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
   logic          d_regwrite, d_md_start, d_md_div, d_md_use;
   logic          stall, md_busy;
   logic [FW-1:0] fwd_rs_d, fwd_rt_d;

   int n_vec = 0;
   int n_bad = 0;

   hazard_scoreboard #(
      .NSTAGE (NSTAGE),
      .TW     (TW),
      .AW     (AW),
      .MUL_CYC(5),
      .DIV_CYC(10)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_a3       (d_a3),
      .d_regwrite (d_regwrite),
      .d_tnew     (d_tnew),
      .d_md_start (d_md_start),
      .d_md_div   (d_md_div),
      .d_md_use   (d_md_use),
      .stall      (stall),
      .fwd_rs_d   (fwd_rs_d),
      .fwd_rt_d   (fwd_rt_d),
      .md_busy    (md_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // D-stage bubble: no reads, no writes, no md activity.
   task automatic d_nop();
      d_rs = '0; d_rt = '0; d_tuse_rs = 3'd5; d_tuse_rt = 3'd5;
      d_a3 = '0; d_regwrite = 1'b0; d_tnew = '0;
      d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
   endtask

   task automatic d_wr(input int a3, input int tnew);
      d_nop();
      d_a3 = AW'(a3); d_regwrite = 1'b1; d_tnew = TW'(tnew);
   endtask

   task automatic d_rd(input int rs, input int trs, input int rt, input int trt);
      d_nop();
      d_rs = AW'(rs); d_tuse_rs = TW'(trs);
      d_rt = AW'(rt); d_tuse_rt = TW'(trt);
   endtask

   // Advance one edge; inputs are changed 1 ns after it, checks after #1 more.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      d_nop();
      tick();
      reset = 1'b0;
   endtask

   task automatic outs(input string tag, input int s, input int frs, input int frt, input int b);
      #1;
      chk({tag, ".stall"},  int'(stall),    s);
      chk({tag, ".fwd_rs"}, int'(fwd_rs_d), frs);
      chk({tag, ".fwd_rt"}, int'(fwd_rt_d), frt);
      chk({tag, ".busy"},   int'(md_busy),  b);
   endtask

   initial begin
      reset = 1'b1;
      d_nop();
      #2;
      outs("reset", 0, 0, 0, 0);
      do_reset();

      // lw $1 (tnew 2) then addu reading $1 (tuse 1): one stall cycle.
      d_wr(1, 2);
      outs("lw_issue", 0, 0, 0, 0);
      tick();
      d_rd(1, 1, 0, 5);
      outs("lwuse_c1", 1, 0, 0, 0);
      tick();
      outs("lwuse_c2", 0, 0, 0, 0);

      // lw $1 then beq $1,$1 (tuse 0): two stalls, then forward from W.
      do_reset();
      d_wr(1, 2);
      tick();
      d_rd(1, 0, 1, 0);
      outs("beq_c1", 1, 0, 0, 0);
      tick();
      outs("beq_c2", 1, 0, 0, 0);
      tick();
      outs("beq_c3", 0, 3, 3, 0);

      // Two writers of $2: youngest (tnew 1) shadows older ready one.
      do_reset();
      d_wr(2, 1);
      tick();
      d_wr(2, 1);
      tick();
      d_rd(2, 0, 2, 1);
      outs("shadow_c1", 1, 0, 0, 0);
      tick();
      outs("shadow_c2", 0, 2, 2, 0);

      // $0 is never a hazard.
      do_reset();
      d_wr(0, 2);
      tick();
      d_rd(0, 0, 0, 0);
      outs("zero_c1", 0, 0, 0, 0);
      tick();
      outs("zero_c2", 0, 0, 0, 0);

      // div then mflo.
      do_reset();
      d_nop();
      d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
      outs("div_issue", 0, 0, 0, 0);
      tick();
      d_nop();
      d_md_use = 1'b1;
      for (int i = 0; i < 10; i++) begin
         outs($sformatf("mflo_%0d", i), MD_ON, 0, 0, MD_ON);
         tick();
      end
      outs("mflo_done", 0, 0, 0, 0);

      // Asynchronous reset while stalled with md_cnt = 7.
      do_reset();
      d_nop();
      d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1;
      tick();
      d_nop();
      tick();
      tick();
      d_wr(1, 2);
      tick();
      d_rd(1, 1, 0, 5);
      outs("pre_rst", 1, 0, 0, MD_ON);
      reset = 1'b1;
      outs("async_rst", 0, 0, 0, 0);
      chk("async_rst.before_edge", int'(clk), 1);
      tick();
      reset = 1'b0;
      outs("post_rst", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
